// File: rtl/booth_mult_arbiter.sv
// Round-robin front end that shares one Booth multiplier datapath/controller
// among NREQ clients: latches the winner's operands, starts, waits, returns the product, clears.
module booth_mult_arbiter #(
  parameter int WIDTH   = 16,
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 2*WIDTH+8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [NREQ*WIDTH-1:0]   opa_in,
  input  logic [NREQ*WIDTH-1:0]   opb_in,
  output logic [NREQ-1:0]         gnt,
  output logic [2*WIDTH-1:0]      res_out,
  output logic [NREQ-1:0]         res_vld,
  output logic                    err,
  output logic                    busy,
  output logic [WIDTH-1:0]        mul_a,
  output logic [WIDTH-1:0]        mul_b,
  output logic                    mul_start,
  output logic                    mul_clr,
  input  logic                    mul_done,
  input  logic [2*WIDTH-1:0]      mul_prod
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO    = CW'(TIMEOUT);
  localparam logic [CW-1:0] TMO_M1 = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_GRANT = 3'd1,
    S_START = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4,
    S_CLR   = 3'd5
  } state_t;

  state_t          state_r;
  logic [IW-1:0]   ptr_r;
  logic [IW-1:0]   win_r;
  logic [CW-1:0]   cnt_r;
  logic [IW-1:0]   pick_s;
  logic            any_req_s;

  function automatic logic [IW-1:0] next_idx(input logic [IW-1:0] i);
    if (i == IW'(NREQ - 1)) begin
      return {IW{1'b0}};
    end else begin
      return i + IW'(1'b1);
    end
  endfunction

  // First requester found scanning upward from p, wrapping modulo NREQ.
  function automatic logic [IW-1:0] rr_pick(input logic [NREQ-1:0] r, input logic [IW-1:0] p);
    logic [IW-1:0] idx;
    logic [IW-1:0] pick;
    logic          found;
    idx   = p;
    pick  = p;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && r[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = next_idx(idx);
    end
    return pick;
  endfunction

  // Round-robin winner selection from the live request vector.
  always_comb begin
    pick_s    = rr_pick(req, ptr_r);
    any_req_s = |req;
  end

  // Sequencer FSM; every output is a register so the datapath sees clean pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= S_IDLE;
      ptr_r     <= {IW{1'b0}};
      win_r     <= {IW{1'b0}};
      cnt_r     <= {CW{1'b0}};
      gnt       <= {NREQ{1'b0}};
      res_out   <= {(2*WIDTH){1'b0}};
      res_vld   <= {NREQ{1'b0}};
      err       <= 1'b0;
      busy      <= 1'b0;
      mul_a     <= {WIDTH{1'b0}};
      mul_b     <= {WIDTH{1'b0}};
      mul_start <= 1'b0;
      mul_clr   <= 1'b1;
    end else begin
      mul_start <= 1'b0;
      mul_clr   <= 1'b0;
      res_vld   <= {NREQ{1'b0}};
      err       <= 1'b0;
      case (state_r)
        S_IDLE: begin
          if (any_req_s) begin
            win_r   <= pick_s;
            gnt     <= NREQ'(1'b1) << pick_s;
            mul_a   <= opa_in[pick_s*WIDTH +: WIDTH];
            mul_b   <= opb_in[pick_s*WIDTH +: WIDTH];
            cnt_r   <= {CW{1'b0}};
            busy    <= 1'b1;
            state_r <= S_GRANT;
          end
        end
        S_GRANT: begin
          mul_start <= 1'b1;
          state_r   <= S_START;
        end
        S_START: begin
          state_r <= S_WAIT;
        end
        S_WAIT: begin
          // Once err has been raised the operation is abandoned even if done arrives late.
          if (cnt_r == TMO) begin
            mul_clr <= 1'b1;
            gnt     <= {NREQ{1'b0}};
            ptr_r   <= next_idx(win_r);
            state_r <= S_CLR;
          end else if (mul_done) begin
            res_out <= mul_prod;
            res_vld <= NREQ'(1'b1) << win_r;
            state_r <= S_DONE;
          end else begin
            cnt_r <= cnt_r + CW'(1'b1);
            if (cnt_r == TMO_M1) begin
              err <= 1'b1;
            end
          end
        end
        S_DONE: begin
          mul_clr <= 1'b1;
          gnt     <= {NREQ{1'b0}};
          ptr_r   <= next_idx(win_r);
          state_r <= S_CLR;
        end
        S_CLR: begin
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
        default: begin
          gnt     <= {NREQ{1'b0}};
          busy    <= 1'b0;
          state_r <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_arbiter.sv
// Directed self-checking bench for booth_mult_arbiter with a behavioural multiplier stub.
module tb_booth_mult_arbiter;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [63:0] opa_in;
  logic [63:0] opb_in;
  logic [3:0]  gnt;
  logic [31:0] res_out;
  logic [3:0]  res_vld;
  logic        err;
  logic        busy;
  logic [15:0] mul_a;
  logic [15:0] mul_b;
  logic        mul_start;
  logic        mul_clr;
  logic        mul_done;
  logic [31:0] mul_prod;

  logic        done_r;
  logic        stale_done;
  logic        stub_auto;
  int          stub_lat;
  int          stub_cnt;

  int checks;
  int errors;

  booth_mult_arbiter #(.WIDTH(16), .NREQ(4), .TIMEOUT(40)) dut (
    .clk(clk), .rst(rst), .req(req), .opa_in(opa_in), .opb_in(opb_in),
    .gnt(gnt), .res_out(res_out), .res_vld(res_vld), .err(err), .busy(busy),
    .mul_a(mul_a), .mul_b(mul_b), .mul_start(mul_start), .mul_clr(mul_clr),
    .mul_done(mul_done), .mul_prod(mul_prod)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Multiplier stub: done rises stub_lat cycles after start, held until clear.
  always @(posedge clk) begin
    if (rst) begin
      done_r   <= 1'b0;
      stub_cnt <= 0;
      mul_prod <= 32'h0;
    end else if (mul_clr) begin
      done_r   <= 1'b0;
      stub_cnt <= 0;
    end else if (mul_start && stub_auto) begin
      stub_cnt <= stub_lat;
    end else if (stub_cnt == 1) begin
      done_r   <= 1'b1;
      mul_prod <= $signed({{16{mul_a[15]}}, mul_a}) * $signed({{16{mul_b[15]}}, mul_b});
      stub_cnt <= 0;
    end else if (stub_cnt > 1) begin
      stub_cnt <= stub_cnt - 1;
    end
  end
  assign mul_done = done_r | stale_done;

  // Requester operands: 0:(7,-3) 1:(100,200) 2:(-5,-6) 3:(-32768,2)
  localparam logic [63:0] OPA = {16'h8000, 16'hFFFB, 16'h0064, 16'h0007};
  localparam logic [63:0] OPB = {16'h0002, 16'hFFFA, 16'h00C8, 16'hFFFD};
  logic [31:0] exp_prod [4];

  task automatic wait_gnt(output logic [3:0] g, output int n);
    n = 0;
    while (gnt == 4'b0000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    g = gnt;
    if (gnt == 4'b0000) n = -1;
  endtask

  task automatic wait_vld(output logic [3:0] v, output int n);
    n = 0;
    while (res_vld == 4'b0000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    v = res_vld;
    if (res_vld == 4'b0000) n = -1;
  endtask

  task automatic wait_gnt_low(output int n);
    n = 0;
    while (gnt != 4'b0000 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (gnt != 4'b0000) n = -1;
  endtask

  task automatic wait_idle(output int n);
    n = 0;
    while (busy && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (busy) n = -1;
  endtask

  task automatic pulse_reset();
    @(negedge clk); rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (gnt !== 4'b0000 || res_vld !== 4'b0000 || busy !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_ctl got gnt=%b vld=%b busy=%b err=%b exp 0000 0000 0 0", gnt, res_vld, busy, err); end
    checks++; if (res_out !== 32'h0 || mul_a !== 16'h0 || mul_b !== 16'h0 || mul_start !== 1'b0) begin
      errors++; $display("FAIL reset_data got res=%h a=%h b=%h start=%b exp all zero", res_out, mul_a, mul_b, mul_start); end
    checks++; if (mul_clr !== 1'b1) begin errors++; $display("FAIL reset_clr got %b exp 1", mul_clr); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mul_clr !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL reset_release got clr=%b busy=%b exp 0 0", mul_clr, busy); end
  endtask

  task automatic test_single();
    logic [3:0] v;
    int n;
    @(negedge clk); req = 4'b0001;
    @(negedge clk); req = 4'b0000;
    checks++; if (gnt !== 4'b0001 || busy !== 1'b1 || mul_start !== 1'b0) begin
      errors++; $display("FAIL single_grant got gnt=%b busy=%b start=%b exp 0001 1 0", gnt, busy, mul_start); end
    checks++; if (mul_a !== 16'h0007 || mul_b !== 16'hFFFD) begin
      errors++; $display("FAIL single_ops got a=%h b=%h exp 0007 fffd", mul_a, mul_b); end
    @(negedge clk);
    checks++; if (mul_start !== 1'b1 || gnt !== 4'b0001) begin
      errors++; $display("FAIL single_start got start=%b gnt=%b exp 1 0001", mul_start, gnt); end
    @(negedge clk);
    checks++; if (mul_start !== 1'b0) begin errors++; $display("FAIL single_start_pulse got %b exp 0", mul_start); end
    wait_vld(v, n);
    checks++; if (n != 4 || v !== 4'b0001) begin
      errors++; $display("FAIL single_vld got n=%0d vld=%b exp 4 0001", n, v); end
    checks++; if (res_out !== 32'hFFFFFFEB) begin errors++; $display("FAIL single_res got %h exp ffffffeb", res_out); end
    @(negedge clk);
    checks++; if (res_vld !== 4'b0000 || mul_clr !== 1'b1 || gnt !== 4'b0000) begin
      errors++; $display("FAIL single_clr got vld=%b clr=%b gnt=%b exp 0000 1 0000", res_vld, mul_clr, gnt); end
    @(negedge clk);
    checks++; if (mul_clr !== 1'b0 || busy !== 1'b0 || res_out !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL single_idle got clr=%b busy=%b res=%h exp 0 0 ffffffeb", mul_clr, busy, res_out); end
  endtask

  task automatic test_round_robin();
    int order [8] = '{0, 1, 2, 3, 0, 2, 0, 2};
    logic [3:0] g, v, eg;
    int n;
    pulse_reset();
    req = 4'b1111;
    for (int k = 0; k < 8; k++) begin
      eg = 4'b0001 << order[k];
      wait_gnt(g, n);
      checks++; if (n < 0 || g !== eg) begin
        errors++; $display("FAIL rr_grant op%0d got %b exp %b", k, g, eg); end
      wait_vld(v, n);
      checks++; if (n < 0 || v !== eg || res_out !== exp_prod[order[k]]) begin
        errors++; $display("FAIL rr_result op%0d got vld=%b res=%h exp %b %h", k, v, res_out, eg, exp_prod[order[k]]); end
      wait_gnt_low(n);
      if (k == 3) req = 4'b0101;
      if (k == 7) req = 4'b0000;
    end
    wait_idle(n);
  endtask

  task automatic test_back_to_back();
    logic [3:0] g, v;
    int n;
    @(negedge clk); req = 4'b0011;
    wait_gnt(g, n);
    checks++; if (n < 0 || g !== 4'b0001) begin errors++; $display("FAIL b2b_first got %b exp 0001", g); end
    wait_vld(v, n);
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || mul_clr !== 1'b1) begin
      errors++; $display("FAIL b2b_clr got gnt=%b clr=%b exp 0000 1", gnt, mul_clr); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0) begin
      errors++; $display("FAIL b2b_idle got gnt=%b busy=%b exp 0000 0", gnt, busy); end
    @(negedge clk);
    checks++; if (gnt !== 4'b0010) begin errors++; $display("FAIL b2b_next got %b exp 0010", gnt); end
    req = 4'b0000;
    wait_vld(v, n);
    checks++; if (n < 0 || v !== 4'b0010 || res_out !== 32'h00004E20) begin
      errors++; $display("FAIL b2b_result got vld=%b res=%h exp 0010 00004e20", v, res_out); end
    wait_idle(n);
  endtask

  task automatic test_operand_isolation();
    logic [3:0] v;
    int n;
    @(negedge clk); req = 4'b0001;
    @(negedge clk);
    checks++; if (gnt !== 4'b0001) begin errors++; $display("FAIL iso_grant got %b exp 0001", gnt); end
    opa_in[15:0] = 16'd50;
    opb_in[15:0] = 16'd9;
    req = 4'b0000;
    @(negedge clk);
    checks++; if (mul_a !== 16'h0007 || mul_b !== 16'hFFFD) begin
      errors++; $display("FAIL iso_ops got a=%h b=%h exp 0007 fffd", mul_a, mul_b); end
    wait_vld(v, n);
    checks++; if (n < 0 || v !== 4'b0001 || res_out !== 32'hFFFFFFEB) begin
      errors++; $display("FAIL iso_result got vld=%b res=%h exp 0001 ffffffeb", v, res_out); end
    opa_in = OPA;
    opb_in = OPB;
    wait_idle(n);
  endtask

  task automatic test_timeout();
    logic [3:0] g, v;
    logic saw_vld;
    int n;
    pulse_reset();
    stub_auto = 1'b0;
    req = 4'b0010;
    @(negedge clk); req = 4'b0000;
    @(negedge clk);
    checks++; if (mul_start !== 1'b1) begin errors++; $display("FAIL tmo_start got %b exp 1", mul_start); end
    n = 0; saw_vld = 1'b0;
    while (!err && n < 200) begin
      @(negedge clk);
      n++;
      if (res_vld != 4'b0000) saw_vld = 1'b1;
    end
    checks++; if (n != 41) begin errors++; $display("FAIL tmo_err_cycle got %0d exp 41", n); end
    checks++; if (mul_clr !== 1'b0 || gnt !== 4'b0010) begin
      errors++; $display("FAIL tmo_err_state got clr=%b gnt=%b exp 0 0010", mul_clr, gnt); end
    @(negedge clk);
    if (res_vld != 4'b0000) saw_vld = 1'b1;
    checks++; if (mul_clr !== 1'b1 || err !== 1'b0 || gnt !== 4'b0000) begin
      errors++; $display("FAIL tmo_clr got clr=%b err=%b gnt=%b exp 1 0 0000", mul_clr, err, gnt); end
    checks++; if (saw_vld !== 1'b0) begin errors++; $display("FAIL tmo_no_vld got %b exp 0", saw_vld); end
    wait_idle(n);
    stub_auto = 1'b1;
    req = 4'b0111;
    wait_gnt(g, n);
    req = 4'b0000;
    checks++; if (n < 0 || g !== 4'b0100) begin errors++; $display("FAIL tmo_ptr got %b exp 0100", g); end
    wait_vld(v, n);
    checks++; if (n < 0 || res_out !== 32'h0000001E) begin errors++; $display("FAIL tmo_next_res got %h exp 0000001e", res_out); end
    wait_idle(n);
  endtask

  task automatic test_stale_done();
    logic [3:0] v;
    int n;
    @(negedge clk); stale_done = 1'b1;
    @(negedge clk);
    checks++; if (busy !== 1'b0 || res_vld !== 4'b0000) begin
      errors++; $display("FAIL stale_idle got busy=%b vld=%b exp 0 0000", busy, res_vld); end
    req = 4'b1000;
    @(negedge clk); req = 4'b0000;
    checks++; if (gnt !== 4'b1000 || res_vld !== 4'b0000) begin
      errors++; $display("FAIL stale_grant got gnt=%b vld=%b exp 1000 0000", gnt, res_vld); end
    @(negedge clk);
    checks++; if (mul_start !== 1'b1 || res_vld !== 4'b0000) begin
      errors++; $display("FAIL stale_start got start=%b vld=%b exp 1 0000", mul_start, res_vld); end
    stale_done = 1'b0;
    wait_vld(v, n);
    checks++; if (n != 5 || v !== 4'b1000 || res_out !== 32'hFFFF0000) begin
      errors++; $display("FAIL stale_result got n=%0d vld=%b res=%h exp 5 1000 ffff0000", n, v, res_out); end
    wait_idle(n);
  endtask

  task automatic test_reset_midop();
    logic [3:0] g, v;
    int n;
    req = 4'b0010;
    wait_gnt(g, n);
    req = 4'b0000;
    wait_vld(v, n);
    wait_idle(n);
    stub_auto = 1'b0;
    req = 4'b0100;
    wait_gnt(g, n);
    req = 4'b0000;
    checks++; if (n < 0 || g !== 4'b0100) begin errors++; $display("FAIL rmid_grant got %b exp 0100", g); end
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    checks++; if (gnt !== 4'b0000 || busy !== 1'b0 || mul_clr !== 1'b1 || res_vld !== 4'b0000 || err !== 1'b0) begin
      errors++; $display("FAIL rmid_abort got gnt=%b busy=%b clr=%b vld=%b err=%b exp 0000 0 1 0000 0", gnt, busy, mul_clr, res_vld, err); end
    rst = 1'b0;
    @(negedge clk);
    checks++; if (mul_clr !== 1'b0 || res_vld !== 4'b0000 || err !== 1'b0) begin
      errors++; $display("FAIL rmid_release got clr=%b vld=%b err=%b exp 0 0000 0", mul_clr, res_vld, err); end
    stub_auto = 1'b1;
    req = 4'b0110;
    wait_gnt(g, n);
    req = 4'b0000;
    checks++; if (n < 0 || g !== 4'b0010) begin errors++; $display("FAIL rmid_ptr got %b exp 0010", g); end
    wait_vld(v, n);
    checks++; if (n < 0 || v !== 4'b0010 || res_out !== 32'h00004E20) begin
      errors++; $display("FAIL rmid_result got vld=%b res=%h exp 0010 00004e20", v, res_out); end
    wait_idle(n);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    exp_prod[0] = 32'hFFFFFFEB;
    exp_prod[1] = 32'h00004E20;
    exp_prod[2] = 32'h0000001E;
    exp_prod[3] = 32'hFFFF0000;
    rst = 1'b1;
    req = 4'b0000;
    opa_in = OPA;
    opb_in = OPB;
    stale_done = 1'b0;
    stub_auto = 1'b1;
    stub_lat = 3;
    test_reset();
    test_single();
    test_round_robin();
    test_back_to_back();
    test_operand_isolation();
    test_timeout();
    test_stale_done();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/booth_mult_arbiter.md
# booth_mult_arbiter

Round-robin arbiter and sequencer that shares one Booth multiplier datapath and its controller among NREQ requesters. It latches the winning requester's operands and pulses the multiplier start. It then waits for done, returns the signed product to the winner and clears the multiplier back to idle. It sits between the client blocks and the Booth datapath/controller pair, and is the only block that drives that pair's start and clear inputs.

## Interface
- WIDTH, 16, operand width; product is 2*WIDTH
- NREQ, 4, number of requesters (2..8)
- TIMEOUT, 2*WIDTH+8, maximum cycles in WAIT before abort
- clk  in  1  single clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req  in  NREQ  per-requester request level
- opa_in  in  NREQ*WIDTH  multiplicand for requester i at [i*WIDTH +: WIDTH]
- opb_in  in  NREQ*WIDTH  multiplier for requester i, same packing
- gnt  out  NREQ  one-hot grant, held from GRANT through DONE
- res_out  out  2*WIDTH  product of last completed operation, held until next DONE
- res_vld  out  NREQ  one-hot, one-cycle pulse to the served requester
- err  out  1  one-cycle pulse on timeout abort
- busy  out  1  high in every state except IDLE
- mul_a  out  WIDTH  registered multiplicand (M) to datapath
- mul_b  out  WIDTH  registered multiplier (Q) to datapath
- mul_start  out  1  one-cycle start pulse to controller
- mul_clr  out  1  one-cycle clear pulse returning controller/datapath to idle
- mul_done  in  1  controller done level (stays high until cleared)
- mul_prod  in  2*WIDTH  datapath product {A,Q}

## Operation
- FSM states: IDLE, GRANT, START, WAIT, DONE, CLR. All outputs registered.
- IDLE: if any req bit is high, select the winner by round-robin starting at index ptr, then ptr+1, and so on, wrapping modulo NREQ. Go to GRANT. Otherwise stay.
- GRANT: gnt = one-hot winner; mul_a/mul_b take the winner's opa/opb; wait counter cleared. Go to START.
- START: mul_start = 1 for exactly this cycle. Go to WAIT.
- WAIT: counter increments each cycle.
  - mul_done high -> capture mul_prod into res_out, go to DONE.
  - Otherwise, when counter reaches TIMEOUT -> err pulse, go to CLR.
- DONE: res_vld[winner] = 1 for one cycle. Go to CLR.
- CLR: mul_clr = 1; gnt = 0; ptr = (winner+1) mod NREQ, updated on timeout too. Go to IDLE.
- mul_done is ignored in every state except WAIT.
- Operands are latched only at GRANT. Later changes on opa_in/opb_in or dropping req do not affect the operation in flight.
- A req that drops before it is granted is not served. No queueing is done.
- The product is passed through unmodified: two's-complement, 2*WIDTH bits, no saturation.
- Reset values: state IDLE, ptr 0, gnt 0, res_vld 0, res_out 0, err 0, busy 0, mul_a 0, mul_b 0, mul_start 0, mul_clr 1.
  - mul_clr stays high while rst is asserted, so the multiplier is forced idle.
  - mul_clr falls the cycle after rst deasserts.
- rst mid-operation: abandon immediately with no res_vld and no err. ptr returns to 0.

## Timing
- Cycle 0: req sampled in IDLE.
- Cycle 1: GRANT, gnt high.
- Cycle 2: mul_start high.
- Cycle 3 onward: WAIT.
- If mul_done is first seen high at cycle t: res_vld and res_out valid at t+1, mul_clr at t+2, IDLE at t+3.
- Earliest next grant is t+4.
- Minimum issue interval per operation is 6 cycles plus the multiplier latency.
- Simultaneous requests: exactly one grant per operation. A continuously requesting client waits at most NREQ-1 operations.
- Timeout: err is asserted on the cycle the counter reaches TIMEOUT. mul_clr follows on the next cycle. No res_vld is issued.

## Test plan
- Single op: req[0]=1, opa=7, opb=-3 (WIDTH=16) -> gnt[0] at cycle 1, mul_start at cycle 2; after done, res_out=32'hFFFFFFEB and res_vld=4'b0001 for exactly one cycle, then mul_clr pulse.
- Round-robin: req=4'b1111 held for 4 operations -> grant order 0,1,2,3; with only req[2] and req[0] held after that, order continues 0,2,0,2.
- Operand isolation: change opa_in[0] and drop req[0] the cycle after GRANT -> result still uses the original operands; res_vld[0] is still pulsed.
- Timeout: model never raises mul_done -> err pulse exactly TIMEOUT cycles after entering WAIT, mul_clr next cycle, no res_vld, ptr advanced.
- Stale done: mul_done held high during IDLE/GRANT/START -> ignored; the product is captured only when done is high in WAIT.
- Reset mid-op: assert rst during WAIT -> next cycle gnt=0, busy=0, mul_clr=1, ptr=0; no res_vld or err; a fresh req[1] after release is served normally.
